// File: rtl/multi_port_fifo.sv
// ---------------------------------------------------------------------------
// multi_port_fifo
//
// In-order FIFO that accepts up to ENQ_PORTS entries and releases up to
// DEQ_PORTS entries per clock. It is intended for use between superscalar
// pipeline stages, where a redirect squashes the buffered contents through
// flush_i.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (pointers and count only)
//   flush_i      synchronous clear; same-cycle enqueues and dequeues are void
//   enq_valid_i  per-slot valid, slot 0 oldest
//   enq_ready_o  per-slot ready, derived from the registered count only
//   enq_data_i   slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   deq_valid_o  per-slot valid, slot 0 is the head entry
//   deq_ready_i  per-slot ready from the consumer
//   deq_data_o   slot i holds entry head+i
//   count_o      occupancy at the start of the cycle
//
// Both handshakes are prefix-contiguous: a slot transfers only if it and
// every lower slot transfer. A gap ends the burst.
//
// Optional feature, macro MULTI_PORT_FIFO_BYPASS_EN:
//   When the FIFO is empty and not flushing, accepted enqueue slots are also
//   presented on the matching dequeue slots in the same cycle. This creates
//   a combinational path from enq_* to deq_*, so deq_ready_i must not feed
//   back into enq_valid_i. Without the macro, every output is derived from
//   registers.
// ---------------------------------------------------------------------------
module multi_port_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ENQ_PORTS  = 2,
  parameter int DEQ_PORTS  = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush_i,
  input  logic [ENQ_PORTS-1:0]            enq_valid_i,
  output logic [ENQ_PORTS-1:0]            enq_ready_o,
  input  logic [ENQ_PORTS*DATA_WIDTH-1:0] enq_data_i,
  output logic [DEQ_PORTS-1:0]            deq_valid_o,
  input  logic [DEQ_PORTS-1:0]            deq_ready_i,
  output logic [DEQ_PORTS*DATA_WIDTH-1:0] deq_data_o,
  output logic [$clog2(DEPTH+1)-1:0]      count_o
);

  localparam int          PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CNT_W    = $clog2(DEPTH + 1);
  localparam int          ENQ_N_W  = $clog2(ENQ_PORTS + 1);
  localparam int          DEQ_N_W  = $clog2(DEQ_PORTS + 1);
  // DEPTH is a power of two, so masking gives the modulo-DEPTH wrap.
  localparam logic [31:0] IDX_MASK = 32'(DEPTH - 1);

  // State
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      head_r;
  logic [PTR_W-1:0]      tail_r;
  logic [CNT_W-1:0]      count_r;

  // Enqueue side
  logic [ENQ_PORTS-1:0]  enq_ready_s;
  logic [ENQ_PORTS-1:0]  enq_acc_s;
  logic [ENQ_N_W-1:0]    n_enq_s;
  logic                  enq_run_s;
  logic [PTR_W-1:0]      wr_idx_s [ENQ_PORTS];

  // Dequeue side
  logic [DEQ_PORTS-1:0]            deq_valid_s;
  logic [DEQ_PORTS*DATA_WIDTH-1:0] deq_data_s;
  logic [DEQ_PORTS-1:0]            deq_pop_s;
  logic [DEQ_N_W-1:0]              n_deq_s;
  logic                            deq_run_s;
  logic [PTR_W-1:0]                rd_idx_s [DEQ_PORTS];

  // Next-state
  logic [PTR_W-1:0] head_nxt_s;
  logic [PTR_W-1:0] tail_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;

`ifdef MULTI_PORT_FIFO_BYPASS_EN
  localparam int MAX_P = (ENQ_PORTS > DEQ_PORTS) ? ENQ_PORTS : DEQ_PORTS;
  // Enqueue vectors zero-padded to the wider port count. This lets the
  // dequeue loop index them without going out of range.
  logic [MAX_P-1:0]            byp_valid_s;
  logic [MAX_P*DATA_WIDTH-1:0] byp_data_s;
  logic                        byp_en_s;

  // Widen the accepted-enqueue view for the bypass path
  always_comb begin
    byp_valid_s                          = '0;
    byp_data_s                           = '0;
    byp_valid_s[ENQ_PORTS-1:0]           = enq_acc_s;
    byp_data_s[ENQ_PORTS*DATA_WIDTH-1:0] = enq_data_i;
    if ((count_r == CNT_W'(0)) && !flush_i) begin
      byp_en_s = 1'b1;
    end else begin
      byp_en_s = 1'b0;
    end
  end
`endif

  // Enqueue ready from free space, and the prefix-contiguous acceptance
  always_comb begin
    enq_ready_s = '0;
    enq_acc_s   = '0;
    n_enq_s     = '0;
    enq_run_s   = 1'b1;
    for (int i = 0; i < ENQ_PORTS; i++) begin
      // The check uses registered count only, so a same-cycle pop does not
      // add space.
      if ((32'(DEPTH) - 32'(count_r)) > 32'(i)) begin
        enq_ready_s[i] = 1'b1;
      end else begin
        enq_ready_s[i] = 1'b0;
      end
      if (enq_run_s && enq_valid_i[i] && enq_ready_s[i]) begin
        enq_acc_s[i] = 1'b1;
        n_enq_s      = n_enq_s + ENQ_N_W'(1);
      end else begin
        enq_run_s = 1'b0;
      end
      wr_idx_s[i] = PTR_W'((32'(tail_r) + 32'(i)) & IDX_MASK);
    end
  end

  // Dequeue valid/data presentation and the prefix-contiguous pop
  always_comb begin
    deq_valid_s = '0;
    deq_data_s  = '0;
    deq_pop_s   = '0;
    n_deq_s     = '0;
    deq_run_s   = 1'b1;
    for (int i = 0; i < DEQ_PORTS; i++) begin
      rd_idx_s[i] = PTR_W'((32'(head_r) + 32'(i)) & IDX_MASK);
      if (32'(count_r) > 32'(i)) begin
        deq_valid_s[i] = 1'b1;
      end else begin
        deq_valid_s[i] = 1'b0;
      end
      deq_data_s[i*DATA_WIDTH +: DATA_WIDTH] = mem_r[rd_idx_s[i]];
`ifdef MULTI_PORT_FIFO_BYPASS_EN
      // When empty, the storage slots are all invalid, so the incoming
      // slots can take their place directly.
      if (byp_en_s) begin
        deq_valid_s[i]                         = byp_valid_s[i];
        deq_data_s[i*DATA_WIDTH +: DATA_WIDTH] = byp_data_s[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        deq_valid_s[i] = deq_valid_s[i];
      end
`endif
      if (deq_run_s && deq_valid_s[i] && deq_ready_i[i]) begin
        deq_pop_s[i] = 1'b1;
        n_deq_s      = n_deq_s + DEQ_N_W'(1);
      end else begin
        deq_run_s = 1'b0;
      end
    end
  end

  // Pointer and occupancy next-state
  always_comb begin
    head_nxt_s  = PTR_W'((32'(head_r) + 32'(n_deq_s)) & IDX_MASK);
    tail_nxt_s  = PTR_W'((32'(tail_r) + 32'(n_enq_s)) & IDX_MASK);
    // A bypass pop occurs only while count is 0, and it pops only entries
    // being enqueued in the same cycle. So n_deq never exceeds count + n_enq.
    count_nxt_s = count_r + CNT_W'(n_enq_s) - CNT_W'(n_deq_s);
  end

  // Pointer/count registers: async reset, flush clears synchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (flush_i) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Storage writes. Contents are not reset. Under bypass, an entry that
  // pops in the same cycle is still written, but into a slot that head
  // skips past, so it is never observed.
  always_ff @(posedge clk) begin
    for (int k = 0; k < ENQ_PORTS; k++) begin
      if (enq_acc_s[k] && !flush_i) begin
        mem_r[wr_idx_s[k]] <= enq_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign enq_ready_o = enq_ready_s;
  assign deq_valid_o = deq_valid_s;
  assign deq_data_o  = deq_data_s;
  assign count_o     = count_r;

endmodule
